// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode/state encodings and the shared single-step shift function.
package shift_reg_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [2:0] {HOLD, SHL, SHR, ROL, ROR, ASR, LOAD, RSVD} shift_mode_e;
  typedef enum logic {IDLE, RUN} shift_fsm_e;
  // r holds a w-bit value zero-extended to MAX_W; w may be 2..MAX_W
  function automatic logic [MAX_W-1:0] shift_step(input logic [MAX_W-1:0] r, input int w,
                                                  input shift_mode_e mode, input logic ser_l,
                                                  input logic ser_r);
    logic [MAX_W-1:0] m, top, hi;
    m = (MAX_W'(1) << w) - MAX_W'(1);
    top = MAX_W'(1) << (w - 1);
    hi = r >> (w - 1);
    return mode == SHL ? ((r << 1) | MAX_W'(ser_l)) & m :
           mode == SHR ? (r >> 1) | (ser_r ? top : '0) :
           mode == ROL ? ((r << 1) | MAX_W'(hi[0])) & m :
           mode == ROR ? (r >> 1) | (r[0] ? top : '0) :
           mode == ASR ? (r >> 1) | (hi[0] ? top : '0) : r;
  endfunction
endpackage

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with parallel load and counted burst sequencer.
// Optional parity_o output enabled by SHIFT_REG_PARITY_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] par_o,
`ifdef SHIFT_REG_PARITY_EN
  output logic             parity_o,
`endif
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o
);
  shift_fsm_e state_q;
  shift_mode_e mode_q, eff_mode, in_mode;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q, r_d, stepped;
  logic idle, accept, last, done_q;
  always_comb begin
    in_mode = shift_mode_e'(mode_i);
    idle = state_q == IDLE;
    accept = idle && start_i && in_mode >= SHL && in_mode <= ASR && cnt_i != '0;
    last = !idle && cnt_q == CNT_W'(1);
    eff_mode = idle ? in_mode : mode_q;
    stepped = WIDTH'(shift_step(MAX_W'(r_q), WIDTH, eff_mode, ser_l_i, ser_r_i));
    // any start request in IDLE (accepted or degenerate) freezes the register for that edge
    r_d = (idle && start_i) ? r_q : eff_mode == LOAD ? par_i : stepped;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q <= HOLD;
      cnt_q <= '0;
      r_q <= RST_VAL;
      done_q <= 1'b0;
    end else begin
      r_q <= r_d;
      done_q <= last || (idle && start_i && !accept);
      state_q <= accept ? RUN : last ? IDLE : state_q;
      mode_q <= accept ? in_mode : mode_q;
      cnt_q <= accept ? cnt_i : idle ? cnt_q : cnt_q - CNT_W'(1);
    end
  end
`ifdef SHIFT_REG_PARITY_EN
  always_ff @(posedge clk_i) parity_o <= rst_i ? ^RST_VAL : ^r_d;
`endif
  assign par_o = r_q;
  assign busy_o = !idle;
  assign done_o = done_q;
  assign ser_o = (eff_mode == SHL || eff_mode == ROL) ? r_q[WIDTH-1] : r_q[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed plus randomized check of shift_reg_univ against an arithmetic model.
module tb_shift_reg_univ;
  logic clk = 1'b0;
  logic rst = 1'b1, sl = 1'b0, sr = 1'b0, start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] par = 8'd0;
  logic [3:0] cnt = 4'd0;
  logic [7:0] par_o;
  logic ser_o, busy_o, done_o;
`ifdef SHIFT_REG_PARITY_EN
  logic parity_o;
`endif
  int total = 0, bad = 0;
  int unsigned mv = 0, mrem = 0, lmode = 0;
  bit mbusy = 0, mdone = 0;

  shift_reg_univ #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .ser_l_i(sl), .ser_r_i(sr), .par_i(par),
    .start_i(start), .cnt_i(cnt), .par_o(par_o),
`ifdef SHIFT_REG_PARITY_EN
    .parity_o(parity_o),
`endif
    .ser_o(ser_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic int unsigned f(int unsigned md, int unsigned v, bit l, bit r);
    case (md)
      1: return (v * 2 + int'(l)) % 256;
      2: return v / 2 + int'(r) * 128;
      3: return (v * 2) % 256 + v / 128;
      4: return v / 2 + (v % 2) * 128;
      5: return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ser();
    int unsigned em;
    em = mbusy ? lmode : int'(mode);
    #1 chk("ser_o", 32'(ser_o), (em == 1 || em == 3) ? 32'(mv / 128) : 32'(mv % 2));
  endtask

  task automatic tick();
    int unsigned nv = mv, nrem = mrem;
    bit nb = mbusy, nd = 1'b0;
    if (rst) begin
      nv = 0; nb = 0; nrem = 0;
    end else if (mbusy) begin
      nv = f(lmode, mv, sl, sr);
      nrem = mrem - 1;
      nb = nrem != 0;
      nd = nrem == 0;
    end else if (start) begin
      if (mode >= 1 && mode <= 5 && cnt != 0) begin
        lmode = mode; nrem = cnt; nb = 1;
      end else nd = 1;
    end else nv = (mode == 6) ? int'(par) : f(mode, mv, sl, sr);
    @(posedge clk);
    #1;
    mv = nv; mrem = nrem; mbusy = nb; mdone = nd;
    chk("par_o", 32'(par_o), 32'(mv));
    chk("busy_o", 32'(busy_o), 32'(mbusy));
    chk("done_o", 32'(done_o), 32'(mdone));
`ifdef SHIFT_REG_PARITY_EN
    chk("parity_o", 32'(parity_o), 32'(^mv[7:0]));
`endif
  endtask

  task automatic drv(input logic [2:0] m, input logic [7:0] p);
    mode = m; par = p; start = 0;
  endtask

  initial begin
    int nb, k;
    rst = 1; mode = 3'($urandom); par = 8'($urandom); start = 1; cnt = 4'($urandom);
    tick();
    mode = 3'($urandom); par = 8'($urandom);
    tick();
    chk("rst_par", 32'(par_o), 32'h00);
    rst = 0;
    drv(6, 8'hA5); tick();
    drv(1, 8'h00); sl = 1; chk_ser();
    chk("ser_pre_shl", 32'(ser_o), 32'h1);
    tick(); chk("shl", 32'(par_o), 32'h4B);
    drv(2, 8'h00); sr = 0; chk_ser(); tick(); chk("shr", 32'(par_o), 32'h25);
    drv(6, 8'h96); tick(); drv(5, 8'h00); chk_ser(); tick(); chk("asr", 32'(par_o), 32'hCB);
    drv(6, 8'h01); tick(); drv(4, 8'h00); chk_ser(); tick(); chk("ror", 32'(par_o), 32'h80);
    drv(3, 8'h00); chk_ser(); tick(); chk("rol", 32'(par_o), 32'h01);
    drv(6, 8'h5A); tick(); drv(7, 8'h00); chk_ser(); tick(); chk("rsvd", 32'(par_o), 32'h5A);
    // burst ROL x3 from 0x81 with LOAD and a second start toggled in while busy
    drv(6, 8'h81); tick();
    mode = 3; start = 1; cnt = 3; tick();
    chk("acc_hold", 32'(par_o), 32'h81);
    drv(6, 8'hFF); chk_ser(); tick(); chk("b1", 32'(par_o), 32'h03);
    start = 1; cnt = 1; chk_ser(); tick(); chk("b2", 32'(par_o), 32'h06);
    start = 0; chk_ser(); tick(); chk("b3", 32'(par_o), 32'h0C);
    chk("b3_done", 32'(done_o), 32'h1);
    mode = 1; sl = 0; start = 1; cnt = 2; tick();
    chk("reaccept", 32'(busy_o), 32'h1);
    drv(0, 8'h00); tick(); tick(); tick();
    // degenerate burst
    mode = 1; start = 1; cnt = 0; tick();
    chk("degen_done", 32'(done_o), 32'h1);
    drv(0, 8'h00); tick();
    mode = 6; start = 1; cnt = 4; tick();
    drv(0, 8'h00); tick();
    // reset in the middle of a burst
    drv(6, 8'hC3); tick();
    mode = 2; start = 1; cnt = 5; tick();
    start = 0; tick(); tick();
    rst = 1; tick();
    rst = 0; drv(0, 8'h00); tick();
    chk("rst_run_done", 32'(done_o), 32'h0);
    // long burst: ROR x15 on 0x01
    drv(6, 8'h01); tick();
    mode = 4; start = 1; cnt = 15; tick();
    drv(0, 8'h00);
    nb = 0; k = 0;
    while (!done_o && k < 20) begin
      if (busy_o) nb++;
      tick();
      k++;
    end
    chk("long_done", 32'(done_o), 32'h1);
    chk("long_busy", 32'(nb), 32'd15);
    chk("long_par", 32'(par_o), 32'h02);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 60) == 0;
      mode = 3'($urandom); par = 8'($urandom); sl = 1'($urandom); sr = 1'($urandom);
      start = ($urandom % 5) == 0; cnt = 4'($urandom);
      if (!rst) chk_ser();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
